// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD frequency setter: converter states, the
// largest legal BCD digit and the minimum binary width for a digit count.
package bcd_pkg;

  localparam int unsigned BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // ceil(digits*log2(10)) == clog2(10**digits), since 10**digits is never a power of two
  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) p = p * 64'd10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the increment/decrement chain (combinational).
// Ports: d in current digit, up/dn in step enables, q out next digit,
//        carry out (9 -> 0 on up), borrow out (0 -> 9 on dn).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       up,
  input  logic       dn,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  always_comb begin
    q      = d;
    carry  = 1'b0;
    borrow = 1'b0;
    if (up && !dn) begin
      if (d == 4'(BCD_MAX_DIGIT)) begin
        q     = 4'd0;
        carry = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end else if (dn && !up) begin
      if (d == 4'd0) begin
        q      = 4'(BCD_MAX_DIGIT);
        borrow = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_freq_setter.sv
// BCD frequency setter: cursor-driven BCD up/down value with a background
// serial BCD-to-binary converter.
// Ports: clk, rst_n (async, active-low); inc/dec step at 10^cursor;
//        cur_l/cur_r move cursor; load/load_bcd direct load (ignored if any
//        nibble > 9); bcd, cursor, bin, bin_valid, busy outputs.
// Macro BCD_FREQ_SETTER_WRAP_EN: overflow/underflow wrap modulo 10^DIGITS
// instead of saturating.
module bcd_freq_setter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       cur_l,
  input  logic                       cur_r,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        load_bcd,
  output logic [4*DIGITS-1:0]        bcd,
  output logic [$clog2(DIGITS)-1:0]  cursor,
  output logic [BIN_W-1:0]           bin,
  output logic                       bin_valid,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(DIGITS);
  localparam int unsigned BW = 4 * DIGITS;

`ifdef BCD_FREQ_SETTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  if (DIGITS < 2 || DIGITS > 9) begin : g_bad_digits
    $error("bcd_freq_setter: DIGITS must be 2..9");
  end
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
    $error("bcd_freq_setter: BIN_W too small for DIGITS");
  end

  logic              inc_op, dec_op;
  logic [DIGITS-1:0] up, dn, cy, bw;
  logic [3:0]        dig_q [DIGITS];
  logic [BW-1:0]     chain_bcd, bcd_next;
  logic              load_ok, bcd_chg;

  conv_state_e       state, state_next;
  logic [BIN_W-1:0]  acc, acc_next, bin_next;
  logic [CW-1:0]     idx, idx_next, cursor_next;
  logic              valid_next;

  assign inc_op = inc & ~dec;
  assign dec_op = dec & ~inc;

  // Ripple chain: the cursor digit gets the step, higher digits take carry/borrow
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign dig_q[i] = bcd[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign up[i] = inc_op && (cursor == CW'(i));
      assign dn[i] = dec_op && (cursor == CW'(i));
    end else begin : g_upper
      assign up[i] = (inc_op && (cursor == CW'(i))) || cy[i-1];
      assign dn[i] = (dec_op && (cursor == CW'(i))) || bw[i-1];
    end
    bcd_digit u_digit (
      .d      (dig_q[i]),
      .up     (up[i]),
      .dn     (dn[i]),
      .q      (chain_bcd[4*i +: 4]),
      .carry  (cy[i]),
      .borrow (bw[i])
    );
  end

  // Load is accepted only when every nibble is a legal BCD digit
  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_bcd[4*i +: 4] > 4'(BCD_MAX_DIGIT)) load_ok = 1'b0;
    end
  end

  // Value update: load beats a step; carry/borrow out of the MSD saturates unless wrapping
  always_comb begin
    bcd_next = bcd;
    if (load && load_ok) begin
      bcd_next = load_bcd;
    end else if (inc_op) begin
      bcd_next = (cy[DIGITS-1] && !WRAP) ? {DIGITS{4'h9}} : chain_bcd;
    end else if (dec_op) begin
      bcd_next = (bw[DIGITS-1] && !WRAP) ? '0 : chain_bcd;
    end
  end

  assign bcd_chg = (bcd_next != bcd);

  // Cursor wraps at both ends; simultaneous moves cancel
  always_comb begin
    cursor_next = cursor;
    if (cur_l && !cur_r) begin
      cursor_next = (cursor == CW'(DIGITS - 1)) ? '0 : cursor + CW'(1);
    end else if (cur_r && !cur_l) begin
      cursor_next = (cursor == '0) ? CW'(DIGITS - 1) : cursor - CW'(1);
    end
  end

  // Converter next state: any value change restarts the MSD-first pass
  always_comb begin
    state_next = state;
    acc_next   = acc;
    idx_next   = idx;
    bin_next   = bin;
    valid_next = 1'b0;
    if (bcd_chg) begin
      state_next = ST_CONV;
      acc_next   = '0;
      idx_next   = CW'(DIGITS - 1);
    end else begin
      unique case (state)
        ST_CONV: begin
          acc_next = BIN_W'(acc * BIN_W'(10)) + BIN_W'(dig_q[idx]);
          if (idx == '0) state_next = ST_DONE;
          else           idx_next   = idx - CW'(1);
        end
        ST_DONE: begin
          bin_next   = acc;
          valid_next = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      idx       <= '0;
      bcd       <= '0;
      cursor    <= '0;
      bin       <= '0;
      bin_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      idx       <= idx_next;
      bcd       <= bcd_next;
      cursor    <= cursor_next;
      bin       <= bin_next;
      bin_valid <= valid_next;
      busy      <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_freq_setter.sv
// Directed self-checking bench for bcd_freq_setter (DIGITS=6, BIN_W=20).
module tb_bcd_freq_setter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc, dec, cur_l, cur_r, load;
  logic [23:0] load_bcd;
  logic [23:0] bcd;
  logic [2:0]  cursor;
  logic [19:0] bin;
  logic        bin_valid, busy;

  int total = 0;
  int bad   = 0;
  int nv;

  always #5 clk = ~clk;

  bcd_freq_setter #(.DIGITS(6), .BIN_W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (inc),
    .dec       (dec),
    .cur_l     (cur_l),
    .cur_r     (cur_r),
    .load      (load),
    .load_bcd  (load_bcd),
    .bcd       (bcd),
    .cursor    (cursor),
    .bin       (bin),
    .bin_valid (bin_valid),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (bin_valid) n++;
    end
  endtask

  task automatic pulse_load(input logic [23:0] v);
    load = 1'b1; load_bcd = v;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_inc();
    inc = 1'b1; tick(); inc = 1'b0;
  endtask

  task automatic pulse_dec();
    dec = 1'b1; tick(); dec = 1'b0;
  endtask

  task automatic move_l(input int n);
    for (int k = 0; k < n; k++) begin
      cur_l = 1'b1; tick(); cur_l = 1'b0;
    end
  endtask

  task automatic move_r(input int n);
    for (int k = 0; k < n; k++) begin
      cur_r = 1'b1; tick(); cur_r = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; inc = 0; dec = 0; cur_l = 0; cur_r = 0; load = 0; load_bcd = '0;
    #3;
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_valid", 32'(bin_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(bin_valid), 32'd0);

    // 000009 + 1 at cursor 0: latency and busy window
    pulse_load(24'h000009);
    chk("load9_bcd", 32'(bcd), 32'h000009);
    wait_idle();
    chk("load9_bin", 32'(bin), 32'd9);
    pulse_inc();
    chk("inc_bcd", 32'(bcd), 32'h000010);
    chk("inc_busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("inc_busy_window", 32'(busy), 32'd1);
      chk("inc_no_early_valid", 32'(bin_valid), 32'd0);
    end
    tick();
    chk("inc_valid", 32'(bin_valid), 32'd1);
    chk("inc_bin", 32'(bin), 32'd10);
    chk("inc_busy_done", 32'(busy), 32'd0);
    tick();
    chk("inc_valid_once", 32'(bin_valid), 32'd0);

    // Overflow at cursor 4
    move_l(4);
    chk("cursor4", 32'(cursor), 32'd4);
    pulse_load(24'h995000);
    wait_idle();
    pulse_inc();
`ifdef BCD_FREQ_SETTER_WRAP_EN
    chk("ovf_bcd", 32'(bcd), 32'h005000);
    wait_idle();
    chk("ovf_bin", 32'(bin), 32'd5000);
`else
    chk("ovf_bcd", 32'(bcd), 32'h999999);
    wait_idle();
    chk("ovf_bin", 32'(bin), 32'd999999);
`endif

    // Underflow at cursor 2
    move_r(2);
    chk("cursor2", 32'(cursor), 32'd2);
    pulse_load(24'h000050);
    wait_idle();
    pulse_dec();
`ifdef BCD_FREQ_SETTER_WRAP_EN
    chk("udf_bcd", 32'(bcd), 32'h999950);
    wait_idle();
    chk("udf_bin", 32'(bin), 32'd999950);
`else
    chk("udf_bcd", 32'(bcd), 32'h000000);
    wait_idle();
    chk("udf_bin", 32'(bin), 32'd0);
`endif
    pulse_load(24'h000050);
    wait_idle();
    inc = 1'b1; dec = 1'b1; tick(); inc = 1'b0; dec = 1'b0;
    chk("incdec_bcd", 32'(bcd), 32'h000050);
    chk("incdec_busy", 32'(busy), 32'd0);
    tick();
    chk("incdec_busy2", 32'(busy), 32'd0);

    // Cursor wrap
    move_l(3);
    chk("cursor5", 32'(cursor), 32'd5);
    move_l(1);
    chk("cursor_wrap_l", 32'(cursor), 32'd0);
    move_r(1);
    chk("cursor_wrap_r", 32'(cursor), 32'd5);
    cur_l = 1'b1; cur_r = 1'b1; tick(); cur_l = 1'b0; cur_r = 1'b0;
    chk("cursor_both", 32'(cursor), 32'd5);

    // Restart mid-conversion: one valid only, for the final value
    move_l(1);
    chk("cursor0", 32'(cursor), 32'd0);
    pulse_load(24'h123456);
    chk("load123456_bcd", 32'(bcd), 32'h123456);
    tick();
    chk("conv1_valid", 32'(bin_valid), 32'd0);
    tick();
    chk("conv2_valid", 32'(bin_valid), 32'd0);
    pulse_inc();
    chk("restart_bcd", 32'(bcd), 32'h123457);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_bin_held", 32'(bin), 32'd50);
    count_valid(12, nv);
    chk("restart_valid_count", 32'(nv), 32'd1);
    chk("restart_bin", 32'(bin), 32'd123457);
    pulse_load(24'h12A456);
    chk("bad_load_bcd", 32'(bcd), 32'h123457);
    chk("bad_load_busy", 32'(busy), 32'd0);

    // Reset mid-conversion
    move_l(1);
    pulse_load(24'h000777);
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bcd), 32'h0);
    chk("mid_rst_cursor", 32'(cursor), 32'd0);
    chk("mid_rst_bin", 32'(bin), 32'd0);
    chk("mid_rst_valid", 32'(bin_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    #3;
    rst_n = 1'b1;
    count_valid(10, nv);
    chk("post_mid_rst_valid", 32'(nv), 32'd0);
    chk("post_mid_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
